// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed N-digit seven-segment driver with blink, leading-zero blanking, dead time and frame tick
module seven_seg_mux #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 100000,
   parameter int DEAD_CYCLES    = 2,
   parameter int BLINK_HALF     = 25000000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blink_en,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      blank_lz,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     dig,
   output logic                      frame_tick
);
   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [SW-1:0] slot_q, slot_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [BW-1:0] blink_q, blink_d;
   logic phase_q, phase_d;
   logic [6:0] seg_q, seg_d;
   logic dp_q, dp_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic ft_q, ft_d;
   logic slot_wrap, blink_wrap, hide, zrun;
   logic [3:0] nib;
   logic [6:0] act;
   logic [NUM_DIGITS-1:0] lz, onehot;
   always_comb begin
      slot_wrap = slot_q == SW'(REFRESH_DIV - 1);
      slot_d = slot_wrap ? '0 : slot_q + SW'(1);
      idx_d = !slot_wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      blink_wrap = blink_q == BW'(BLINK_HALF - 1);
      blink_d = blink_wrap ? '0 : blink_q + BW'(1);
      phase_d = phase_q ^ blink_wrap;
      ft_d = slot_wrap && (idx_q == IW'(NUM_DIGITS - 1));
      // lz[i] set when every nibble from the top down to i is zero
      zrun = 1'b1;
      lz = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zrun = zrun & (digits[4*i +: 4] == 4'h0);
         lz[i] = zrun;
      end
      nib = digits[{idx_q, 2'b00} +: 4];
      hide = blink_en && blink_mask[idx_q] && phase_q;
      act = (hide || (blank_lz && lz[idx_q])) ? 7'h00 : FONT[nib];
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~act : act;
      dp_d = DP_OFF ^ (dp_in[idx_q] && !hide);
      onehot = NUM_DIGITS'(1) << idx_q;
      dig_d = (int'(slot_q) < DEAD_CYCLES) ? DIG_OFF : DIG_OFF ^ onehot;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q <= '0;
         idx_q <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
         seg_q <= SEG_OFF;
         dp_q <= DP_OFF;
         dig_q <= DIG_OFF;
         ft_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         idx_q <= idx_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         seg_q <= seg_d;
         dp_q <= dp_d;
         dig_q <= dig_d;
         ft_q <= ft_d;
      end
   end
   assign seg = seg_q;
   assign dp = dp_q;
   assign dig = dig_q;
   assign frame_tick = ft_q;
endmodule
